// File: rtl/haru_pkg.sv
// Shared definitions for the DTW result path: result-word field offsets,
// summary-word layout and the hit-filter state encoding.
package haru_pkg;

    localparam int SCORE_W   = 16;
    localparam int POS_W     = 16;
    localparam int AXI_DW    = 32;

    // Result word: [31:16] score, [15:0] ref position
    localparam int SCORE_MSB = 31;
    localparam int SCORE_LSB = 16;
    localparam int POS_MSB   = 15;
    localparam int POS_LSB   = 0;

    // Second summary word: hit flag on top, hit count in the low half
    localparam int SUM_PAD_W = AXI_DW - 1 - SCORE_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_CAP  = 3'd2,
        ST_SUM0 = 3'd3,
        ST_SUM1 = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/dtw_min_tracker.sv
// Running minimum score, its ref position, and a saturating count of scores
// below the threshold. clear restarts all three for a new query.
module dtw_min_tracker #(
    parameter int SCORE_W = 16,
    parameter int POS_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [POS_W-1:0]   i_pos,
    input  logic [SCORE_W-1:0] i_threshold,
    output logic [SCORE_W-1:0] o_min_score,
    output logic [POS_W-1:0]   o_min_pos,
    output logic [SCORE_W-1:0] o_hit_cnt
);

    logic [SCORE_W-1:0] r_min_score;
    logic [POS_W-1:0]   r_min_pos;
    logic [SCORE_W-1:0] r_hit_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_min_score <= '1;
            r_min_pos   <= '0;
            r_hit_cnt   <= '0;
        end else if (i_valid) begin
            // Strict compare keeps the first occurrence on a tie
            if (i_score < r_min_score) begin
                r_min_score <= i_score;
                r_min_pos   <= i_pos;
            end
            if ((i_score < i_threshold) && (r_hit_cnt != '1))
                r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign o_min_score = r_min_score;
    assign o_min_pos   = r_min_pos;
    assign o_hit_cnt   = r_hit_cnt;

endmodule

// File: rtl/dtw_hit_filter.sv
// Drains dtw_core result words, tracks min score / position / hit count over
// one query, then pushes a two-word summary. Handshake: rden and wren are
// only asserted when the corresponding FIFO is not empty / not full.
module dtw_hit_filter
    import haru_pkg::*;
#(
    parameter int SCORE_W = 16,
    parameter int POS_W   = 16,
    parameter int AXI_DW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic [31:0]       res_len,
    input  logic [SCORE_W-1:0] threshold,
    output logic              busy,
    output logic              done,
    output logic              src_fifo_rden,
    input  logic              src_fifo_empty,
    input  logic [AXI_DW-1:0] src_fifo_data,
    output logic              sink_fifo_wren,
    input  logic              sink_fifo_full,
    output logic [AXI_DW-1:0] sink_fifo_data,
    output logic [SCORE_W-1:0] min_score,
    output logic [POS_W-1:0]  min_pos,
    output logic [2:0]        dbg_state
);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_res_len;
    logic [31:0]        r_rcv_cnt;
    logic [SCORE_W-1:0] r_thr;
    logic               w_start;
    logic               w_cap;
    logic [SCORE_W-1:0] w_hit_cnt;
    logic               w_hit;

    assign w_start = (r_state == ST_IDLE) && running;
    assign w_cap   = (r_state == ST_CAP);

    dtw_min_tracker #(.SCORE_W(SCORE_W), .POS_W(POS_W)) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start),
        .i_valid     (w_cap),
        .i_score     (src_fifo_data[SCORE_MSB:SCORE_LSB]),
        .i_pos       (src_fifo_data[POS_MSB:POS_LSB]),
        .i_threshold (r_thr),
        .o_min_score (min_score),
        .o_min_pos   (min_pos),
        .o_hit_cnt   (w_hit_cnt)
    );

    assign w_hit = (min_score < r_thr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_res_len <= '0;
            r_thr     <= '0;
            r_rcv_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_res_len <= res_len;
                r_thr     <= threshold;
                r_rcv_cnt <= '0;
            end else if (w_cap) begin
                r_rcv_cnt <= r_rcv_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        busy           = 1'b0;
        done           = 1'b0;
        src_fifo_rden  = 1'b0;
        sink_fifo_wren = 1'b0;
        sink_fifo_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (running)
                    w_next = (res_len == 32'd0) ? ST_SUM0 : ST_POP;
            end
            ST_POP: begin
                busy          = 1'b1;
                src_fifo_rden = !src_fifo_empty;
                if (!src_fifo_empty)
                    w_next = ST_CAP;
            end
            ST_CAP: begin
                busy   = 1'b1;
                w_next = ((r_rcv_cnt + 32'd1) == r_res_len) ? ST_SUM0 : ST_POP;
            end
            ST_SUM0: begin
                busy           = 1'b1;
                sink_fifo_data = {min_score, min_pos};
                sink_fifo_wren = !sink_fifo_full;
                if (!sink_fifo_full)
                    w_next = ST_SUM1;
            end
            ST_SUM1: begin
                busy           = 1'b1;
                sink_fifo_data = {w_hit, {SUM_PAD_W{1'b0}}, w_hit_cnt};
                sink_fifo_wren = !sink_fifo_full;
                if (!sink_fifo_full)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_dtw_hit_filter.sv
// Directed bench for dtw_hit_filter: FIFO models on both sides, a per-query
// summary model, and a negedge monitor that checks every write and handshake.
module tb_dtw_hit_filter;
    import haru_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        running = 1'b0;
    logic [31:0] res_len = '0;
    logic [15:0] threshold = '0;
    logic        busy, done, src_fifo_rden, sink_fifo_wren;
    logic        src_fifo_empty = 1'b1;
    logic [31:0] src_fifo_data = '0;
    logic        sink_fifo_full = 1'b0;
    logic [31:0] sink_fifo_data;
    logic [15:0] min_score, min_pos;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int  pop_cnt = 0;
    int  done_cnt = 0;
    int  writes_this_run = 0;
    int  cyc = 0;
    bit  gap_en = 0;
    bit  pend_pop = 0;
    bit  prev_done = 0;

    dtw_hit_filter dut (
        .clk(clk), .rst(rst), .running(running), .res_len(res_len),
        .threshold(threshold), .busy(busy), .done(done),
        .src_fifo_rden(src_fifo_rden), .src_fifo_empty(src_fifo_empty),
        .src_fifo_data(src_fifo_data), .sink_fifo_wren(sink_fifo_wren),
        .sink_fifo_full(sink_fifo_full), .sink_fifo_data(sink_fifo_data),
        .min_score(min_score), .min_pos(min_pos), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Summary straight from the query rules: strict minimum with first
    // occurrence kept, saturating count of scores below threshold.
    function automatic void model_summary(input logic [31:0] words[$], input logic [15:0] thr,
                                          output logic [31:0] w0, output logic [31:0] w1);
        int best = 65535;
        int best_pos = 0;
        int hits = 0;
        foreach (words[i]) begin
            int s = int'(words[i][31:16]);
            if (s < best) begin
                best = s;
                best_pos = int'(words[i][15:0]);
            end
            if (s < int'(thr) && hits < 65535) hits++;
        end
        w0 = {best[15:0], best_pos[15:0]};
        w1 = {(best < int'(thr)), 15'b0, hits[15:0]};
    endfunction

    // Monitor / FIFO models, all on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_pop) begin
                if (src_q.size() > 0) src_fifo_data = src_q.pop_front();
                pop_cnt++;
                pend_pop = 0;
            end
            src_fifo_empty = (src_q.size() == 0) || (gap_en && (cyc % 8 == 7));
            #1;
            if (rst) writes_this_run = 0;
            if (src_fifo_rden) begin
                check("rden_while_empty", {31'b0, src_fifo_empty}, 32'd0);
                pend_pop = 1;
            end
            if (sink_fifo_wren) begin
                check("wren_while_full", {31'b0, sink_fifo_full}, 32'd0);
                check("busy_on_write", {31'b0, busy}, 32'd1);
                got_q.push_back(sink_fifo_data);
                writes_this_run++;
                if (exp_q.size() == 0) check("unexpected_write", sink_fifo_data, 32'hDEAD_BEEF);
                else check("summary_word", sink_fifo_data, exp_q.pop_front());
            end
            if (done) begin
                check("done_writes", writes_this_run, 32'd2);
                check("done_busy", {31'b0, busy}, 32'd0);
                check("done_single", {31'b0, prev_done}, 32'd0);
                writes_this_run = 0;
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic start_query(input logic [31:0] words[$], input logic [15:0] thr, input bit push_exp);
        logic [31:0] w0, w1;
        got_q.delete();
        foreach (words[i]) src_q.push_back(words[i]);
        if (push_exp) begin
            model_summary(words, thr, w0, w1);
            exp_q.push_back(w0);
            exp_q.push_back(w1);
        end
        @(posedge clk); #1;
        res_len = words.size();
        threshold = thr;
        running = 1'b1;
        @(posedge clk); #1;
        running = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_done_seen"}, done_cnt, d0 + 1);
        @(posedge clk); #1;
    endtask

    task automatic run_query(input string name, input logic [31:0] words[$], input logic [15:0] thr);
        logic [31:0] w0, w1;
        int d0 = done_cnt;
        start_query(words, thr, 1'b1);
        wait_done(name, d0, 3 * words.size() + 200);
        model_summary(words, thr, w0, w1);
        check({name, "_min_score_hold"}, {16'b0, min_score}, {16'b0, w0[31:16]});
        check({name, "_min_pos_hold"}, {16'b0, min_pos}, {16'b0, w0[15:0]});
        check({name, "_exp_drained"}, exp_q.size(), 32'd0);
        check({name, "_src_drained"}, src_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] words[$];
        logic [31:0] m0, m1, d_hold;
        int p0, k, d0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rden", {31'b0, src_fifo_rden}, 32'd0);
        check("rst_wren", {31'b0, sink_fifo_wren}, 32'd0);
        check("rst_data", sink_fifo_data, 32'd0);
        check("rst_min_score", {16'b0, min_score}, 32'h0000_FFFF);
        check("rst_min_pos", {16'b0, min_pos}, 32'd0);
        rst = 1'b0;

        // Basic query, literal pins on model and DUT
        words = '{32'h012C_0000, 32'h0032_0001, 32'h0032_0002, 32'h0014_0003};
        model_summary(words, 16'd100, m0, m1);
        check("model_basic_w0", m0, 32'h0014_0003);
        check("model_basic_w1", m1, 32'h8000_0003);
        run_query("basic", words, 16'd100);
        check("basic_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h0014_0003);
        check("basic_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'h8000_0003);

        // Tie: first occurrence wins, no hits
        words = '{32'h0046_0005, 32'h0046_0006, 32'h005A_0007};
        run_query("tie", words, 16'd60);
        check("tie_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h0046_0005);
        check("tie_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'h0000_0000);

        // Empty query: no pops at all
        words.delete();
        p0 = pop_cnt;
        run_query("empty", words, 16'd500);
        check("empty_no_pops", pop_cnt - p0, 32'd0);
        check("empty_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'hFFFF_0000);
        check("empty_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'h0000_0000);

        // Long query with periodic source gaps, including saturated scores
        words.delete();
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] s = (i % 97 == 0) ? 16'hFFFF : 16'($urandom_range(40, 65535));
            words.push_back({s, 16'(i)});
        end
        gap_en = 1;
        p0 = pop_cnt;
        run_query("gaps", words, 16'd30000);
        check("gaps_all_popped", pop_cnt - p0, 32'd1000);
        gap_en = 0;

        // Sink full held 20 cycles at SUM0
        words = '{32'h0010_0001, 32'h0008_0002};
        sink_fifo_full = 1'b1;
        d0 = done_cnt;
        start_query(words, 16'd9, 1'b1);
        k = 0;
        while (dbg_state != 3'(ST_SUM0) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("full_reached_sum0", {29'b0, dbg_state}, {29'b0, 3'(ST_SUM0)});
        d_hold = sink_fifo_data;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("full_no_wren", {31'b0, sink_fifo_wren}, 32'd0);
            check("full_data_stable", sink_fifo_data, d_hold);
        end
        check("full_held_data", d_hold, 32'h0008_0002);
        sink_fifo_full = 1'b0;
        wait_done("full", d0, 50);
        check("full_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'h8000_0001);

        // Reset after 10 of 100 words aborts the query with no summary
        words.delete();
        for (int i = 0; i < 100; i++) words.push_back({16'(1000 + i), 16'(i)});
        p0 = pop_cnt;
        start_query(words, 16'd2000, 1'b0);
        k = 0;
        while (pop_cnt < p0 + 10 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_reached_10", {31'b0, (pop_cnt >= p0 + 10)}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_rden", {31'b0, src_fifo_rden}, 32'd0);
        check("abort_wren", {31'b0, sink_fifo_wren}, 32'd0);
        check("abort_data", sink_fifo_data, 32'd0);
        check("abort_min_score", {16'b0, min_score}, 32'h0000_FFFF);
        check("abort_min_pos", {16'b0, min_pos}, 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        src_q.delete();
        words = '{32'h00C8_000A, 32'h0064_000B, 32'h0190_000C};
        run_query("after_rst", words, 16'd150);
        check("after_rst_w0", got_q.size() > 0 ? got_q[0] : 32'hX, 32'h0064_000B);
        check("after_rst_w1", got_q.size() > 1 ? got_q[1] : 32'hX, 32'h8000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
